// File: rtl/tile_renderer_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tile_renderer_pipe
// Brief    : Two-stage playfield renderer: border, palette cells, background.
// Revision : 1.0 - initial release
// ============================================================================
module tile_renderer_pipe #(
    parameter int          BLOCK_SIZE   = 24,
    parameter int          GRID_COLS    = 10,
    parameter int          GRID_ROWS    = 20,
    parameter int          GRID_X0      = 200,
    parameter int          GRID_Y0      = 0,
    parameter int          BORDER       = 4,
    parameter logic [11:0] BORDER_COLOR = 12'hF00,
    parameter logic [11:0] BG_COLOR     = 12'h00F,
    parameter int          FLASH_FRAMES = 8,
    parameter bit          GAP_EN       = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pix_valid,
    input  logic [9:0]                   pix_x,
    input  logic [9:0]                   pix_y,
    input  logic                         frame_start,
    input  logic [GRID_ROWS-1:0]         flash_rows,
    output logic [$clog2(GRID_ROWS)-1:0] grid_row_addr,
    input  logic [GRID_COLS*4-1:0]       grid_row_data,
    output logic                         out_valid,
    output logic [11:0]                  pixel_color
);
    localparam int c_col_w = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
    localparam int c_row_w = $clog2(GRID_ROWS);
    localparam int c_sub_w = $clog2(BLOCK_SIZE);
    localparam int c_fc_w  = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    localparam logic [31:0] c_x0  = 32'(GRID_X0);
    localparam logic [31:0] c_x1  = 32'(GRID_X0 + GRID_COLS * BLOCK_SIZE);
    localparam logic [31:0] c_xb0 = 32'(GRID_X0 - BORDER);
    localparam logic [31:0] c_xb1 = 32'(GRID_X0 + GRID_COLS * BLOCK_SIZE + BORDER);
    localparam logic [31:0] c_y0  = 32'(GRID_Y0);
    localparam logic [31:0] c_y1  = 32'(GRID_Y0 + GRID_ROWS * BLOCK_SIZE);
    localparam logic [31:0] c_yb1 = 32'(GRID_Y0 + GRID_ROWS * BLOCK_SIZE + BORDER);

    localparam logic [c_sub_w-1:0] c_sub_last   = c_sub_w'(BLOCK_SIZE - 1);
    localparam logic [c_row_w-1:0] c_row_last   = c_row_w'(GRID_ROWS - 1);
    localparam logic [c_fc_w-1:0]  c_frame_last = c_fc_w'(FLASH_FRAMES - 1);

    localparam logic [1:0] c_reg_bg     = 2'd0;
    localparam logic [1:0] c_reg_border = 2'd1;
    localparam logic [1:0] c_reg_grid   = 2'd2;

    function automatic logic [11:0] palette(input logic [3:0] nib);
        case (nib)
            4'd1:    palette = 12'hF00;
            4'd2:    palette = 12'h0F0;
            4'd3:    palette = 12'h00F;
            4'd4:    palette = 12'hFF0;
            4'd5:    palette = 12'h0FF;
            4'd6:    palette = 12'hF0F;
            4'd7:    palette = 12'h888;
            default: palette = 12'hFFF;
        endcase
    endfunction

    logic [31:0]        w_px, w_py;
    logic               w_in_gx, w_in_gy, w_side, w_bottom;
    logic [1:0]         w_region;
    logic [c_col_w-1:0] r_col, w_col;
    logic [c_row_w-1:0] r_row, w_row;
    logic [c_sub_w-1:0] r_sub_x, w_sub_x, r_sub_y, w_sub_y;
    logic [3:0]         w_nibble;
    logic               w_flash;
    logic [c_fc_w-1:0]  r_frame_cnt;
    logic               r_flash_phase;

    logic               r1_valid, r1_flash, r1_phase;
    logic [1:0]         r1_region;
    logic [c_sub_w-1:0] r1_sub_x, r1_sub_y;
    logic [3:0]         r1_nibble;
    logic [11:0]        w_color;

    assign w_px = {22'd0, pix_x};
    assign w_py = {22'd0, pix_y};
    assign grid_row_addr = r_row;

    always_comb begin
        w_in_gx  = (w_px >= c_x0) && (w_px < c_x1);
        w_in_gy  = (w_py >= c_y0) && (w_py < c_y1);
        w_side   = ((w_px >= c_xb0 && w_px < c_x0) || (w_px >= c_x1 && w_px < c_xb1))
                   && (w_py >= c_y0) && (w_py < c_yb1);
        w_bottom = (w_py >= c_y1) && (w_py < c_yb1) && (w_px >= c_xb0) && (w_px < c_xb1);
        if (w_side || w_bottom)
            w_region = c_reg_border;
        else if (w_in_gx && w_in_gy)
            w_region = c_reg_grid;
        else
            w_region = c_reg_bg;
    end

    // w_* are the cell coordinates of the pixel on the bus this cycle
    always_comb begin
        w_col   = r_col;
        w_sub_x = r_sub_x;
        if (w_px == c_x0) begin
            w_col   = '0;
            w_sub_x = '0;
        end else if (w_in_gx) begin
            if (r_sub_x == c_sub_last) begin
                w_sub_x = '0;
                w_col   = r_col + 1'b1;
            end else begin
                w_sub_x = r_sub_x + 1'b1;
            end
        end

        w_row   = r_row;
        w_sub_y = r_sub_y;
        if (pix_x == 10'd0) begin
            if (w_py == c_y0) begin
                w_row   = '0;
                w_sub_y = '0;
            end else if (w_in_gy) begin
                if (r_sub_y == c_sub_last) begin
                    w_sub_y = '0;
                    if (r_row != c_row_last)
                        w_row = r_row + 1'b1;
                end else begin
                    w_sub_y = r_sub_y + 1'b1;
                end
            end
        end
    end

    // The read port follows r_row, which is settled for every pixel after x==0
    always_comb begin
        w_nibble = 4'd0;
        for (int c = 0; c < GRID_COLS; c++)
            if (w_col == c_col_w'(c))
                w_nibble = grid_row_data[4*c +: 4];
        w_flash = 1'b0;
        for (int r = 0; r < GRID_ROWS; r++)
            if (w_row == c_row_w'(r))
                w_flash = flash_rows[r];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col   <= '0;
            r_sub_x <= '0;
            r_row   <= '0;
            r_sub_y <= '0;
        end else if (pix_valid) begin
            r_col   <= w_col;
            r_sub_x <= w_sub_x;
            r_row   <= w_row;
            r_sub_y <= w_sub_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt   <= '0;
            r_flash_phase <= 1'b0;
        end else if (frame_start) begin
            if (r_frame_cnt == c_frame_last) begin
                r_frame_cnt   <= '0;
                r_flash_phase <= ~r_flash_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // Phase is captured with the pixel so a coincident frame_start renders with the old phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid  <= 1'b0;
            r1_region <= c_reg_bg;
            r1_sub_x  <= '0;
            r1_sub_y  <= '0;
            r1_flash  <= 1'b0;
            r1_phase  <= 1'b0;
            r1_nibble <= 4'd0;
        end else begin
            r1_valid  <= pix_valid;
            r1_region <= w_region;
            r1_sub_x  <= w_sub_x;
            r1_sub_y  <= w_sub_y;
            r1_flash  <= w_flash;
            r1_phase  <= r_flash_phase;
            r1_nibble <= w_nibble;
        end
    end

    always_comb begin
        w_color = BG_COLOR;
        case (r1_region)
            c_reg_border: w_color = BORDER_COLOR;
            c_reg_grid: begin
                if (r1_flash && r1_phase)
                    w_color = 12'hFFF;
                else if (GAP_EN && (r1_nibble != 4'd0) && (r1_sub_x == '0 || r1_sub_y == '0))
                    w_color = 12'h000;
                else
                    w_color = palette(r1_nibble);
            end
            default: w_color = BG_COLOR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            pixel_color <= 12'h000;
        end else begin
            out_valid   <= r1_valid;
            pixel_color <= r1_valid ? w_color : 12'h000;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_renderer_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_renderer_pipe
// Brief    : Scoreboard bench for tile_renderer_pipe against a divider-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_renderer_pipe;
    localparam int BS  = 24;
    localparam int GC  = 10;
    localparam int GR  = 20;
    localparam int X0  = 200;
    localparam int Y0  = 0;
    localparam int BRD = 4;
    localparam int FF  = 2;
    localparam int W   = GC * BS;
    localparam int H   = GR * BS;

    logic          clk;
    logic          rst_n;
    logic          pix_valid;
    logic [9:0]    pix_x, pix_y;
    logic          frame_start;
    logic [GR-1:0] flash_rows;
    logic [4:0]    grid_row_addr;
    logic [GC*4-1:0] grid_row_data;
    logic          out_valid;
    logic [11:0]   pixel_color;

    logic [GC*4-1:0] grid_mem [GR];
    assign grid_row_data = grid_mem[grid_row_addr];

    tile_renderer_pipe #(.FLASH_FRAMES(FF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_valid    (pix_valid),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .frame_start  (frame_start),
        .flash_rows   (flash_rows),
        .grid_row_addr(grid_row_addr),
        .grid_row_data(grid_row_data),
        .out_valid    (out_valid),
        .pixel_color  (pixel_color)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          x;
        int          y;
        logic [11:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pulses = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] model_color(input int x, input int y, input bit phase);
        int         col, row, sx, sy;
        logic [3:0] nib;
        if (((x >= X0 - BRD && x < X0) || (x >= X0 + W && x < X0 + W + BRD)) &&
            y >= Y0 && y < Y0 + H + BRD)
            return 12'hF00;
        if (y >= Y0 + H && y < Y0 + H + BRD && x >= X0 - BRD && x < X0 + W + BRD)
            return 12'hF00;
        if (x >= X0 && x < X0 + W && y >= Y0 && y < Y0 + H) begin
            col = (x - X0) / BS;
            sx  = (x - X0) % BS;
            row = (y - Y0) / BS;
            sy  = (y - Y0) % BS;
            nib = grid_mem[row][4*col +: 4];
            if (flash_rows[row] && phase) return 12'hFFF;
            if (nib != 4'd0 && (sx == 0 || sy == 0)) return 12'h000;
            case (nib)
                4'd0: return 12'hFFF;
                4'd1: return 12'hF00;
                4'd2: return 12'h0F0;
                4'd3: return 12'h00F;
                4'd4: return 12'hFF0;
                4'd5: return 12'h0FF;
                4'd6: return 12'hF0F;
                4'd7: return 12'h888;
                default: return 12'hFFF;
            endcase
        end
        return 12'h00F;
    endfunction

    function automatic bit full_line(input int y);
        return (y == 100 || y == 120 || y == 125 || y == 240 || y == 245 ||
                y == 290 || y == 479 || y == 481);
    endfunction

    task automatic drive(input bit v, input int x, input int y, input bit fs);
        bit ph;
        @(posedge clk);
        #1;
        pix_valid   = v;
        pix_x       = 10'(x);
        pix_y       = 10'(y);
        frame_start = fs;
        ph = ((n_pulses / FF) % 2) == 1;
        if (v && rst_n) exp_q.push_back('{x, y, model_color(x, y, ph)});
        if (fs && rst_n) n_pulses++;
    endtask

    task automatic run_frame(input int last_y, input int fs_y, input int fs_x);
        for (int y = 0; y <= last_y; y++) begin
            int xmax;
            xmax = full_line(y) ? 449 : 0;
            for (int x = 0; x <= xmax; x++)
                drive(1'b1, x, y, (y == fs_y && x == fs_x));
            drive(1'b0, 0, y, 1'b0);
            if (y == 100) check("row_addr_l100", 32'(grid_row_addr), 32'd4);
            if (y == 479) check("row_addr_l479", 32'(grid_row_addr), 32'd19);
            if (y == 483) check("row_addr_sat", 32'(grid_row_addr), 32'd19);
        end
        repeat (3) drive(1'b0, 0, 0, 1'b0);
        if (fs_y < 0) drive(1'b0, 0, 0, 1'b1);
    endtask

    // Scoreboard: every valid output pops one expectation, idle outputs must be black
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            check("sb_depth", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("pix(%0d,%0d)", e.x, e.y), 32'(pixel_color), 32'(e.c));
            end
        end else begin
            check("idle_color", 32'(pixel_color), 32'd0);
        end
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        pix_valid   = 1'b0;
        pix_x       = '0;
        pix_y       = '0;
        frame_start = 1'b0;
        flash_rows  = '0;
        for (int r = 0; r < GR; r++) grid_mem[r] = '0;
        grid_mem[4][2*4 +: 4]  = 4'd3;
        grid_mem[5]            = {GC{4'h2}};
        grid_mem[19][9*4 +: 4] = 4'd7;
        for (int c = 0; c < GC; c++) grid_mem[10][c*4 +: 4] = 4'(c);
        for (int c = 0; c < 6; c++) grid_mem[12][c*4 +: 4] = 4'(10 + c);
        grid_mem[12][6*4 +: 4] = 4'd1;
        grid_mem[12][7*4 +: 4] = 4'd4;
        grid_mem[12][8*4 +: 4] = 4'd5;
        grid_mem[12][9*4 +: 4] = 4'd6;

        // Reset held while the video bus toggles
        for (int i = 0; i < 6; i++) drive(i[0], 250 + i, 100, 1'b0);
        drive(1'b0, 0, 0, 1'b0);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_color", 32'(pixel_color), 32'd0);
        check("rst_addr", 32'(grid_row_addr), 32'd0);
        rst_n = 1'b1;

        // First-pixel latency
        drive(1'b1, 196, 100, 1'b0);
        @(negedge clk);
        check("lat_c0", 32'(out_valid), 32'd0);
        drive(1'b0, 0, 0, 1'b0);
        @(negedge clk);
        check("lat_c1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_c2", 32'(out_valid), 32'd1);

        // Full frame: border, background, palette, gaps, counter wrap, row saturation
        run_frame(483, -1, 0);

        // Mid-line asynchronous reset at (300,200)
        for (int y = 0; y < 200; y++) begin
            drive(1'b1, 0, y, 1'b0);
            drive(1'b0, 0, y, 1'b0);
        end
        for (int x = 0; x <= 300; x++) drive(1'b1, x, 200, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_color", 32'(pixel_color), 32'd0);
        check("midrst_addr", 32'(grid_row_addr), 32'd0);
        exp_q.delete();
        n_pulses = 0;
        drive(1'b0, 0, 0, 1'b0);
        drive(1'b0, 0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Flash frames; frame 1 ends with frame_start coincident with pixel (300,125)
        flash_rows[5] = 1'b1;
        for (int f = 0; f < 6; f++)
            run_frame(125, (f == 1) ? 125 : -1, 300);

        repeat (5) drive(1'b0, 0, 0, 1'b0);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
